cpc_mem_arbiter: RTL and testbench

- Shares the single CPC system RAM port between the CPU and the video fetch, using a fixed 1 us slot (4 MHz CPC timing).
- Each slot has two halves:
  - Video half: two byte fetches (one 16-bit word) for the pixel path.
  - CPU half: at most one CPU byte access.
- The CPU is stalled through cpu_nwait_o until its access completes, which reproduces the gate-array wait-state alignment.
- Sits between the Z80 bus/ramsel bank mapping, the CRTC video address path and the external RAM controller.

---
 rtl/cpc_arb_pkg.sv | 24 ++
 rtl/cpc_slot_timer.sv | 32 +++
 rtl/cpc_mem_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_cpc_mem_arbiter.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpc_arb_pkg.sv
// Shared types and constants for the CPC RAM-port arbiter.
// Optional build macro: CPC_ARB_CPU_STEAL_EN (see cpc_mem_arbiter).
package cpc_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VID_B0,
    VID_B1,
    VID_DONE,
    CPU_ACC,
    CPU_DONE
  } arb_state_e;

  localparam int SLOT_CYCLES_DEF = 16;
  localparam int HALF_SLOT       = SLOT_CYCLES_DEF / 2;

  // Video always fetches from bank 0: upper address bits are forced to zero.
  localparam logic [31:0] VID_BANK0_EXT = 32'h0;

  function automatic int half_of(input int slot_cycles);
    return slot_cycles / 2;
  endfunction

endpackage

// File: rtl/cpc_slot_timer.sv
// Free-running 1 us slot phase counter; flags slot start and the CPU half.
module cpc_slot_timer
  import cpc_arb_pkg::*;
#(
  parameter int SLOT_CYCLES = SLOT_CYCLES_DEF,
  parameter int PHASE_W     = $clog2(SLOT_CYCLES)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  output logic [PHASE_W-1:0] phase_o,
  output logic               slot_start_o,
  output logic               cpu_half_o
);

  localparam int HALF = half_of(SLOT_CYCLES);

  logic [PHASE_W-1:0] phase_q, phase_d;

  always_comb begin
    phase_d = (phase_q == PHASE_W'(SLOT_CYCLES - 1)) ? '0 : phase_q + PHASE_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) phase_q <= '0;
    else         phase_q <= phase_d;
  end

  assign phase_o      = phase_q;
  assign slot_start_o = (phase_q == '0);
  assign cpu_half_o   = (phase_q >= PHASE_W'(HALF));

endmodule

// File: rtl/cpc_mem_arbiter.sv
// Time-slot arbiter sharing the CPC RAM port between video fetch and CPU.
// Build macro CPC_ARB_CPU_STEAL_EN: CPU may use an idle video half-slot.
module cpc_mem_arbiter
  import cpc_arb_pkg::*;
#(
  parameter int SLOT_CYCLES = SLOT_CYCLES_DEF,
  parameter int ADDR_W      = 22
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [7:0]        cpu_dat_i,
  output logic [7:0]        cpu_dat_o,
  output logic              cpu_ack_o,
  output logic              cpu_nwait_o,
  input  logic              vid_req_i,
  input  logic [14:0]       vid_addr_i,
  output logic [15:0]       vid_dat_o,
  output logic              vid_ack_o,
  output logic              vid_overrun_o,
  output logic              mem_stb_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_dat_o,
  input  logic [7:0]        mem_dat_i,
  input  logic              mem_ack_i
);

  localparam int PW   = $clog2(SLOT_CYCLES);
  localparam int HALF = half_of(SLOT_CYCLES);

  logic [PW-1:0] phase;
  logic          slot_start;
  logic          cpu_half;
  logic          cpu_window;

  cpc_slot_timer #(.SLOT_CYCLES(SLOT_CYCLES), .PHASE_W(PW)) u_timer (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .phase_o      (phase),
    .slot_start_o (slot_start),
    .cpu_half_o   (cpu_half)
  );

  arb_state_e        state_q,    state_d;
  logic              mem_stb_q,  mem_stb_d;
  logic              mem_we_q,   mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_dat_q,  mem_dat_d;
  logic [15:0]       vid_dat_q,  vid_dat_d;
  logic              vid_ack_q,  vid_ack_d;
  logic              overrun_q,  overrun_d;
  logic              vid_pend_q, vid_pend_d;
  logic [14:0]       vid_addr_q, vid_addr_d;
  logic [7:0]        cpu_dat_q,  cpu_dat_d;
  logic              cpu_ack_q,  cpu_ack_d;
  logic              served_q,   served_d;

  logic mem_xfer;
  logic vid_go;
  logic served_now;

  assign mem_xfer   = mem_stb_q & mem_ack_i;
  assign vid_go     = (slot_start & vid_req_i) | vid_pend_q;
  assign served_now = served_q & ~slot_start;

`ifdef CPC_ARB_CPU_STEAL_EN
  logic steal_q, steal_d;
  always_comb begin
    steal_d = slot_start ? ~vid_req_i : steal_q;
  end
  assign cpu_window = cpu_half | steal_q | (slot_start & ~vid_req_i);
`else
  assign cpu_window = cpu_half;
`endif

  always_comb begin
    // NOTE: every _d gets a default first, so no path through the case infers a latch.
    state_d    = state_q;
    mem_stb_d  = mem_stb_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_dat_d  = mem_dat_q;
    vid_dat_d  = vid_dat_q;
    vid_ack_d  = 1'b0;
    overrun_d  = overrun_q;
    vid_pend_d = vid_pend_q;
    vid_addr_d = vid_addr_q;
    cpu_dat_d  = cpu_dat_q;
    cpu_ack_d  = 1'b0;
    served_d   = served_q;

    // Video is sampled once per slot; it waits here if a CPU cycle spans the wrap.
    if (slot_start) begin
      served_d = 1'b0;
      if (vid_req_i) begin
        vid_pend_d = 1'b1;
        vid_addr_d = vid_addr_i;
      end
    end

    if ((phase >= PW'(HALF)) && (state_q == VID_B0 || state_q == VID_B1))
      overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (vid_go) begin
          state_d    = VID_B0;
          vid_pend_d = 1'b0;
          mem_stb_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {VID_BANK0_EXT[ADDR_W-17:0],
                        (vid_pend_q ? vid_addr_q : vid_addr_i), 1'b0};
        end else if (cpu_window && cpu_req_i && !served_now) begin
          state_d    = CPU_ACC;
          mem_stb_d  = 1'b1;
          mem_we_d   = cpu_we_i;
          mem_addr_d = cpu_addr_i;
          mem_dat_d  = cpu_dat_i;
        end
      end
      VID_B0: begin
        if (mem_xfer) begin
          state_d        = VID_B1;
          vid_dat_d[7:0] = mem_dat_i;
          mem_addr_d     = mem_addr_q | ADDR_W'(1);
        end
      end
      VID_B1: begin
        if (mem_xfer) begin
          state_d         = VID_DONE;
          vid_dat_d[15:8] = mem_dat_i;
          mem_stb_d       = 1'b0;
          vid_ack_d       = 1'b1;
        end
      end
      VID_DONE: state_d = IDLE;
      CPU_ACC: begin
        if (mem_xfer) begin
          state_d   = CPU_DONE;
          mem_stb_d = 1'b0;
          mem_we_d  = 1'b0;
          cpu_ack_d = 1'b1;
          served_d  = 1'b1;
          if (!mem_we_q) cpu_dat_d = mem_dat_i;
        end
      end
      CPU_DONE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (reset_i) begin
      state_q    <= IDLE;
      mem_stb_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_dat_q  <= '0;
      vid_dat_q  <= '0;
      vid_ack_q  <= 1'b0;
      overrun_q  <= 1'b0;
      vid_pend_q <= 1'b0;
      vid_addr_q <= '0;
      cpu_dat_q  <= '0;
      cpu_ack_q  <= 1'b0;
      served_q   <= 1'b0;
`ifdef CPC_ARB_CPU_STEAL_EN
      steal_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mem_stb_q  <= mem_stb_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_dat_q  <= mem_dat_d;
      vid_dat_q  <= vid_dat_d;
      vid_ack_q  <= vid_ack_d;
      overrun_q  <= overrun_d;
      vid_pend_q <= vid_pend_d;
      vid_addr_q <= vid_addr_d;
      cpu_dat_q  <= cpu_dat_d;
      cpu_ack_q  <= cpu_ack_d;
      served_q   <= served_d;
`ifdef CPC_ARB_CPU_STEAL_EN
      steal_q    <= steal_d;
`endif
    end
  end

  assign mem_stb_o     = mem_stb_q;
  assign mem_we_o      = mem_we_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_dat_o     = mem_dat_q;
  assign vid_dat_o     = vid_dat_q;
  assign vid_ack_o     = vid_ack_q;
  assign vid_overrun_o = overrun_q;
  assign cpu_dat_o     = cpu_dat_q;
  assign cpu_ack_o     = cpu_ack_q;
  // Stall must drop in the very cycle the CPU raises its request.
  assign cpu_nwait_o   = ~cpu_req_i | cpu_ack_q;

endmodule

// File: tb/tb_cpc_mem_arbiter.sv
// Scoreboard bench for cpc_mem_arbiter with a variable-latency RAM model.
module tb_cpc_mem_arbiter;

  typedef struct {
    logic [15:0] data;
    int          phase;
  } exp_t;

  typedef struct {
    logic [21:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        cpu_req_i = 1'b0;
  logic        cpu_we_i = 1'b0;
  logic [21:0] cpu_addr_i = '0;
  logic [7:0]  cpu_dat_i = '0;
  logic [7:0]  cpu_dat_o;
  logic        cpu_ack_o;
  logic        cpu_nwait_o;
  logic        vid_req_i = 1'b0;
  logic [14:0] vid_addr_i = '0;
  logic [15:0] vid_dat_o;
  logic        vid_ack_o;
  logic        vid_overrun_o;
  logic        mem_stb_o;
  logic        mem_we_o;
  logic [21:0] mem_addr_o;
  logic [7:0]  mem_dat_o;
  logic [7:0]  mem_dat_i;
  logic        mem_ack_i;

  logic [7:0] ram [0:65535];
  int         lat = 0;
  int         lat_cnt = 0;
  logic [3:0] tb_phase = '0;

  int n_cmp = 0;
  int n_err = 0;

  exp_t vid_q[$];
  exp_t cpu_q[$];
  wr_t  wr_q[$];

  cpc_mem_arbiter dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .cpu_req_i     (cpu_req_i),
    .cpu_we_i      (cpu_we_i),
    .cpu_addr_i    (cpu_addr_i),
    .cpu_dat_i     (cpu_dat_i),
    .cpu_dat_o     (cpu_dat_o),
    .cpu_ack_o     (cpu_ack_o),
    .cpu_nwait_o   (cpu_nwait_o),
    .vid_req_i     (vid_req_i),
    .vid_addr_i    (vid_addr_i),
    .vid_dat_o     (vid_dat_o),
    .vid_ack_o     (vid_ack_o),
    .vid_overrun_o (vid_overrun_o),
    .mem_stb_o     (mem_stb_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_dat_o     (mem_dat_o),
    .mem_dat_i     (mem_dat_i),
    .mem_ack_i     (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  assign mem_ack_i = mem_stb_o && (lat_cnt >= lat);
  assign mem_dat_i = ram[mem_addr_o[15:0]];

  always @(posedge clk_i) begin
    if (reset_i || !mem_stb_o || mem_ack_i) lat_cnt <= 0;
    else                                    lat_cnt <= lat_cnt + 1;
    if (mem_stb_o && mem_ack_i && mem_we_o) ram[mem_addr_o[15:0]] <= mem_dat_o;
    tb_phase <= reset_i ? 4'd0 : tb_phase + 4'd1;
  end

  task automatic wait_phase(input int p);
    bit hit = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk_i);
      if (tb_phase == 4'(p)) hit = 1;
    end
    if (!hit) begin
      n_cmp++; n_err++;
      $display("FAIL wait_phase: phase %0d never reached (now %0d)", p, tb_phase);
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #1;
    n_cmp++;
    if ({mem_stb_o, mem_we_o, cpu_ack_o, vid_ack_o, vid_overrun_o} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b expected 00000",
               {mem_stb_o, mem_we_o, cpu_ack_o, vid_ack_o, vid_overrun_o});
    end
    n_cmp++;
    if ({mem_addr_o, mem_dat_o, vid_dat_o, cpu_dat_o} !== '0) begin
      n_err++;
      $display("FAIL reset_data: got addr=%h mdat=%h vdat=%h cdat=%h expected all 0",
               mem_addr_o, mem_dat_o, vid_dat_o, cpu_dat_o);
    end
    n_cmp++;
    if (cpu_nwait_o !== 1'b1) begin
      n_err++;
      $display("FAIL reset_nwait: got %b expected 1", cpu_nwait_o);
    end
    reset_i = 1'b0;
  endtask

  task automatic test_video();
    int          nack = 0;
    exp_t        e;
    logic [21:0] exp_addr;
    logic        exp_stb;
    lat = 0;
    vid_q.push_back('{16'h55AA, 3});
    wait_phase(15);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i);
      vid_req_i  = (tb_phase == 4'd0);
      vid_addr_i = 15'h1234;
      #1;
      exp_stb  = (tb_phase == 4'd1) || (tb_phase == 4'd2);
      exp_addr = (tb_phase == 4'd1) ? 22'h002468 : 22'h002469;
      n_cmp++;
      if (mem_stb_o !== exp_stb || (exp_stb && (mem_addr_o !== exp_addr || mem_we_o !== 1'b0))) begin
        n_err++;
        $display("FAIL vid_bus ph%0d: got stb=%b we=%b addr=%h expected stb=%b we=0 addr=%h",
                 tb_phase, mem_stb_o, mem_we_o, mem_addr_o, exp_stb, exp_addr);
      end
      if (vid_ack_o === 1'b1) begin
        nack++;
        n_cmp++;
        if (vid_q.size() == 0) begin
          n_err++;
          $display("FAIL vid_ack_extra: got ack at ph%0d expected none", tb_phase);
        end else begin
          e = vid_q.pop_front();
          if (vid_dat_o !== e.data || int'(tb_phase) != e.phase) begin
            n_err++;
            $display("FAIL vid_ack: got dat=%h ph%0d expected dat=%h ph%0d",
                     vid_dat_o, tb_phase, e.data, e.phase);
          end
        end
      end
    end
    n_cmp++;
    if (nack != 1) begin
      n_err++;
      $display("FAIL vid_ack_count: got %0d expected 1", nack);
    end
  endtask

  task automatic test_cpu_read();
    int   nack = 0;
    exp_t e;
    logic exp_nwait, exp_stb;
    lat = 0;
    ram[16'hC000] = 8'h3C;
    cpu_q.push_back('{16'h003C, 10});
    wait_phase(15);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i);
      vid_req_i = (tb_phase == 4'd0);
      if (tb_phase == 4'd2) begin
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 22'h01C000;
      end
      #1;
      exp_nwait = !(tb_phase >= 4'd2 && tb_phase <= 4'd9);
      exp_stb   = (tb_phase == 4'd1) || (tb_phase == 4'd2) || (tb_phase == 4'd9);
      n_cmp++;
      if (cpu_nwait_o !== exp_nwait || mem_stb_o !== exp_stb) begin
        n_err++;
        $display("FAIL cpu_rd_timing ph%0d: got nwait=%b stb=%b expected nwait=%b stb=%b",
                 tb_phase, cpu_nwait_o, mem_stb_o, exp_nwait, exp_stb);
      end
      if (tb_phase == 4'd9) begin
        n_cmp++;
        if (mem_addr_o !== 22'h01C000 || mem_we_o !== 1'b0) begin
          n_err++;
          $display("FAIL cpu_rd_addr: got addr=%h we=%b expected 01c000 we=0", mem_addr_o, mem_we_o);
        end
      end
      if (cpu_ack_o === 1'b1) begin
        nack++;
        n_cmp++;
        e = cpu_q.pop_front();
        if ({8'h00, cpu_dat_o} !== e.data || int'(tb_phase) != e.phase) begin
          n_err++;
          $display("FAIL cpu_rd_ack: got dat=%h ph%0d expected dat=%h ph%0d",
                   cpu_dat_o, tb_phase, e.data[7:0], e.phase);
        end
        cpu_req_i = 1'b0;
      end
    end
    vid_req_i = 1'b0;
    n_cmp++;
    if (nack != 1 || cpu_req_i !== 1'b0) begin
      n_err++;
      $display("FAIL cpu_rd_count: got %0d acks expected 1", nack);
    end
  endtask

  task automatic test_back_to_back();
    int  k = 0;
    int  nwr = 0;
    int  per_slot [4] = '{0, 0, 0, 0};
    wr_t w;
    lat = 0;
    wait_phase(15);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_i);
      vid_req_i = (tb_phase == 4'd0);
      if (i == 0) begin
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b1;
        cpu_addr_i = 22'h300000;
        cpu_dat_i  = 8'hA0;
        wr_q.push_back('{22'h300000, 8'hA0});
      end
      #1;
      n_cmp++;
      if (cpu_nwait_o !== (cpu_ack_o | ~cpu_req_i)) begin
        n_err++;
        $display("FAIL b2b_nwait ph%0d: got %b expected %b", tb_phase, cpu_nwait_o,
                 cpu_ack_o | ~cpu_req_i);
      end
      if (mem_stb_o && mem_ack_i && mem_we_o) begin
        nwr++;
        per_slot[i / 16]++;
        n_cmp++;
        w = wr_q.pop_front();
        if (mem_addr_o !== w.addr || mem_dat_o !== w.data || tb_phase < 4'd8) begin
          n_err++;
          $display("FAIL b2b_write: got addr=%h dat=%h ph%0d expected addr=%h dat=%h in cpu half",
                   mem_addr_o, mem_dat_o, tb_phase, w.addr, w.data);
        end
      end
      if (cpu_ack_o === 1'b1) begin
        k++;
        if (k < 4) begin
          cpu_addr_i = 22'h300000 + 22'(k);
          cpu_dat_i  = 8'hA0 + 8'(k);
          wr_q.push_back('{22'h300000 + 22'(k), 8'hA0 + 8'(k)});
        end else begin
          cpu_req_i = 1'b0;
        end
      end
    end
    vid_req_i = 1'b0;
    cpu_req_i = 1'b0;
    cpu_we_i  = 1'b0;
    n_cmp++;
    if (nwr != 4 || per_slot[0] != 1 || per_slot[1] != 1 || per_slot[2] != 1 || per_slot[3] != 1) begin
      n_err++;
      $display("FAIL b2b_count: got %0d writes (%0d/%0d/%0d/%0d) expected 4 (1/1/1/1)",
               nwr, per_slot[0], per_slot[1], per_slot[2], per_slot[3]);
    end
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (ram[16'(j)] !== 8'hA0 + 8'(j)) begin
        n_err++;
        $display("FAIL b2b_ram[%0d]: got %h expected %h", j, ram[16'(j)], 8'hA0 + 8'(j));
      end
    end
  endtask

  task automatic test_overrun();
    int   nack = 0;
    exp_t e;
    logic exp_ovr, exp_stb;
    lat = 5;
    ram[16'h0200] = 8'h11;
    ram[16'h0201] = 8'h22;
    vid_q.push_back('{16'h2211, 13});
    wait_phase(15);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk_i);
      vid_req_i  = (i == 0);
      vid_addr_i = 15'h0100;
      #1;
      exp_ovr = (i >= 9);
      exp_stb = (i >= 1 && i <= 12);
      n_cmp++;
      if (vid_overrun_o !== exp_ovr || mem_stb_o !== exp_stb) begin
        n_err++;
        $display("FAIL overrun cyc%0d: got ovr=%b stb=%b expected ovr=%b stb=%b",
                 i, vid_overrun_o, mem_stb_o, exp_ovr, exp_stb);
      end
      if (vid_ack_o === 1'b1) begin
        nack++;
        n_cmp++;
        e = vid_q.pop_front();
        if (vid_dat_o !== e.data || int'(tb_phase) != e.phase) begin
          n_err++;
          $display("FAIL overrun_ack: got dat=%h ph%0d expected dat=%h ph%0d",
                   vid_dat_o, tb_phase, e.data, e.phase);
        end
      end
    end
    n_cmp++;
    if (nack != 1) begin
      n_err++;
      $display("FAIL overrun_ack_count: got %0d expected 1", nack);
    end
    lat = 0;
  endtask

  task automatic test_reset_mid();
    int nack = 0;
    lat = 0;
    wait_phase(15);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk_i);
      vid_req_i = (tb_phase == 4'd0);
      if (tb_phase == 4'd4) lat = 5;
      if (tb_phase == 4'd5) begin
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 22'h000040;
      end
      #1;
    end
    n_cmp++;
    if (mem_stb_o !== 1'b1 || mem_addr_o !== 22'h000040 || vid_overrun_o !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_pre: got stb=%b addr=%h ovr=%b expected stb=1 addr=000040 ovr=1",
               mem_stb_o, mem_addr_o, vid_overrun_o);
    end
    reset_i   = 1'b1;
    cpu_req_i = 1'b0;
    @(negedge clk_i);
    #1;
    n_cmp++;
    if (mem_stb_o !== 1'b0 || cpu_ack_o !== 1'b0 || cpu_nwait_o !== 1'b1 ||
        vid_overrun_o !== 1'b0 || dut.u_timer.phase_o !== 4'd0) begin
      n_err++;
      $display("FAIL rst_mid_post: got stb=%b ack=%b nwait=%b ovr=%b phase=%0d expected 0 0 1 0 0",
               mem_stb_o, cpu_ack_o, cpu_nwait_o, vid_overrun_o, dut.u_timer.phase_o);
    end
    reset_i = 1'b0;
    lat     = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk_i);
      #1;
      if (cpu_ack_o === 1'b1 || mem_stb_o === 1'b1) nack++;
    end
    n_cmp++;
    if (nack != 0) begin
      n_err++;
      $display("FAIL rst_mid_no_ack: got %0d ack/stb cycles expected 0", nack);
    end
  endtask

  task automatic test_steal();
    int   nack = 0;
    exp_t e;
    lat = 0;
    ram[16'h0080] = 8'h77;
`ifdef CPC_ARB_CPU_STEAL_EN
    cpu_q.push_back('{16'h0077, 2});
`else
    cpu_q.push_back('{16'h0077, 10});
`endif
    wait_phase(15);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i);
      vid_req_i = 1'b0;
      if (i == 0) begin
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 22'h000080;
      end
      #1;
      if (cpu_ack_o === 1'b1) begin
        nack++;
        n_cmp++;
        e = cpu_q.pop_front();
        if ({8'h00, cpu_dat_o} !== e.data || int'(tb_phase) != e.phase) begin
          n_err++;
          $display("FAIL steal_ack: got dat=%h ph%0d expected dat=%h ph%0d",
                   cpu_dat_o, tb_phase, e.data[7:0], e.phase);
        end
        cpu_req_i = 1'b0;
      end
    end
    n_cmp++;
    if (nack != 1) begin
      n_err++;
      $display("FAIL steal_count: got %0d acks expected 1", nack);
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) ram[a] = 8'h00;
    ram[16'h2468] = 8'hAA;
    ram[16'h2469] = 8'h55;
    test_reset();
    test_video();
    test_cpu_read();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    test_steal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
